// File: rtl/main_memory_responder.sv
// Purpose : memory-side responder for the cache strobe interface; also serves as the simulation memory model.
// Latency : request sampled on edge E0 -> MReady pulses for one cycle after edge E0+WAIT_STATES+1.
// Backpr. : none; one request in flight, and a strobe while busy is dropped and flagged in ProtoErr.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   MStrobe            single-cycle request pulse from the cache; MRW/MAddr/MDataIn sampled with it
//   MRW                1 = write, 0 = read
//   MAddr, MDataIn     word address and write data
//   MDataOut           registered read data; holds until the next read commits
//   MReady             one-cycle completion pulse
//   Busy               registered "request in flight"; trails the FSM state by one cycle
//   ProtoErr           sticky flag: strobe arrived while a request was outstanding
module main_memory_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 4,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              Busy,
    output logic              ProtoErr
);

    // The counter is only ever loaded with WAIT_STATES and decremented down to 1,
    // so it never wraps. A zero wait count still needs a one-bit register.
    localparam int CTR_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(WAIT_STATES);
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Commit happens on whichever edge enters RESPOND. With no wait states that
    // edge is the accepting edge itself, so the commit address/data must come
    // straight from the request inputs rather than from the latches.
    logic              commit_wr;
    logic              commit_rd;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic              proto_set;

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Next-state and commit decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        commit_wr   = 1'b0;
        commit_rd   = 1'b0;
        commit_addr = addr_q;
        commit_data = data_q;
        proto_set   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MStrobe) begin
                    rw_d   = MRW;
                    addr_d = MAddr;
                    data_d = MDataIn;
                    ctr_d  = CTR_LOAD;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d     = S_RESPOND;
                        commit_wr   = MRW;
                        commit_rd   = ~MRW;
                        commit_addr = MAddr;
                        commit_data = MDataIn;
                    end
                end
            end

            S_WAIT: begin
                proto_set = MStrobe;
                ctr_d     = ctr_q - CTR_ONE;
                if (ctr_q == CTR_ONE) begin
                    state_d   = S_RESPOND;
                    commit_wr = rw_q;
                    commit_rd = ~rw_q;
                end
            end

            S_RESPOND: begin
                proto_set = MStrobe;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latches and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctr_q    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            MDataOut <= '0;
            MReady   <= 1'b0;
            Busy     <= 1'b0;
            ProtoErr <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            // Both flags are registered from the current state, so MReady
            // fires in the cycle after RESPOND and Busy trails WAIT/RESPOND
            // by one cycle.
            MReady  <= (state_q == S_RESPOND);
            Busy    <= (state_q != S_IDLE);
            if (proto_set) begin
                ProtoErr <= 1'b1;
            end
            if (commit_rd) begin
                MDataOut <= mem[commit_addr];
            end
        end
    end

    // Storage is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit_wr) begin
            mem[commit_addr] <= commit_data;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

    logic        clk;

    // DUT with four wait states
    logic        rst4, strobe4, rw4;
    logic [7:0]  addr4;
    logic [31:0] din4, dout4;
    logic        rdy4, busy4, perr4;

    // DUT with zero wait states
    logic        rst0, strobe0, rw0;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0;
    logic        rdy0, busy0, perr0;

    int n_tests = 0;
    int n_fail  = 0;

    main_memory_responder #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(4)) dut4 (
        .clk(clk), .reset(rst4), .MStrobe(strobe4), .MRW(rw4), .MAddr(addr4),
        .MDataIn(din4), .MDataOut(dout4), .MReady(rdy4), .Busy(busy4), .ProtoErr(perr4)
    );

    main_memory_responder #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst0), .MStrobe(strobe0), .MRW(rw0), .MAddr(addr0),
        .MDataIn(din0), .MDataOut(dout0), .MReady(rdy0), .Busy(busy0), .ProtoErr(perr0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic        strobe;
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] din;
        logic        exp_rdy;
        logic        exp_busy;
        logic [31:0] exp_dout;
        logic        exp_perr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic rw, input logic [7:0] a, input logic [31:0] d,
                       input logic er, input logic eb, input logic [31:0] ed, input logic ep);
        vec_t v;
        v.strobe = s;  v.rw = rw; v.addr = a; v.din = d;
        v.exp_rdy = er; v.exp_busy = eb; v.exp_dout = ed; v.exp_perr = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for MReady. lat counts edges after the
    // accepting edge up to the one after which MReady is seen high.
    task automatic req(input bit sel0, input logic rw, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output int lat);
        if (sel0) begin
            strobe0 = 1'b1; rw0 = rw; addr0 = a; din0 = d;
        end else begin
            strobe4 = 1'b1; rw4 = rw; addr4 = a; din4 = d;
        end
        tick();
        strobe0 = 1'b0;
        strobe4 = 1'b0;
        lat = 0;
        while (!(sel0 ? rdy0 : rdy4) && lat < 20) begin
            tick();
            lat++;
        end
        rdata = sel0 ? dout0 : dout4;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          rdy_seen;

        rst4 = 1'b1; strobe4 = 1'b0; rw4 = 1'b0; addr4 = '0; din4 = '0;
        rst0 = 1'b1; strobe0 = 1'b0; rw0 = 1'b0; addr0 = '0; din0 = '0;
        tick();
        tick();

        // Reset state of both instances
        chk("reset4_dout", dout4, 32'h0);
        chk("reset4_rdy",  {31'b0, rdy4},  32'h0);
        chk("reset4_busy", {31'b0, busy4}, 32'h0);
        chk("reset4_perr", {31'b0, perr4}, 32'h0);
        chk("reset0_dout", dout0, 32'h0);
        chk("reset0_busy", {31'b0, busy0}, 32'h0);
        rst4 = 1'b0;
        rst0 = 1'b0;

        // Tests 1 and 2: write 0x10 then read it back, cycle by cycle.
        //   strobe rw  addr   din           rdy busy dout          perr
        add(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0); // E0
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0); // E1
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0); // E2
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0); // E3
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0); // E4
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0); // E5
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0); // E6
        add(1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0); // read E0
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0);
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0);
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0);
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0); // entered RESPOND
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0); // MReady
        add(1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            strobe4 = vecs[i].strobe;
            rw4     = vecs[i].rw;
            addr4   = vecs[i].addr;
            din4    = vecs[i].din;
            tick();
            chk($sformatf("vec%0d_rdy", i),  {31'b0, rdy4},  {31'b0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_busy", i), {31'b0, busy4}, {31'b0, vecs[i].exp_busy});
            chk($sformatf("vec%0d_dout", i), dout4,          vecs[i].exp_dout);
            chk($sformatf("vec%0d_perr", i), {31'b0, perr4}, {31'b0, vecs[i].exp_perr});
        end
        strobe4 = 1'b0;

        // Test 3: strobe a write to 0x20 one cycle into a read of 0x10.
        req(1'b0, 1'b1, 8'h20, 32'hCAFEF00D, rd, lat);
        chk("t3_prewrite_lat", lat, 5);
        strobe4 = 1'b1; rw4 = 1'b0; addr4 = 8'h10; din4 = 32'h0;
        tick();
        strobe4 = 1'b1; rw4 = 1'b1; addr4 = 8'h20; din4 = 32'h11111111;
        tick();
        strobe4 = 1'b0;
        chk("t3_perr_set", {31'b0, perr4}, 32'h1);
        lat = 1;
        while (!rdy4 && lat < 20) begin
            tick();
            lat++;
        end
        chk("t3_read_lat",  lat,   5);
        chk("t3_read_data", dout4, 32'hDEADBEEF);
        req(1'b0, 1'b0, 8'h20, 32'h0, rd, lat);
        chk("t3_mem20_unchanged", rd, 32'hCAFEF00D);
        chk("t3_perr_sticky", {31'b0, perr4}, 32'h1);

        // Test 4: reset during WAIT of a write to 0x30.
        req(1'b0, 1'b1, 8'h30, 32'h0BADF00D, rd, lat);
        strobe4 = 1'b1; rw4 = 1'b1; addr4 = 8'h30; din4 = 32'h12345678;
        tick();
        strobe4 = 1'b0;
        tick();
        tick();
        rst4 = 1'b1;
        tick();
        chk("t4_rst_dout", dout4, 32'h0);
        chk("t4_rst_rdy",  {31'b0, rdy4},  32'h0);
        chk("t4_rst_busy", {31'b0, busy4}, 32'h0);
        chk("t4_rst_perr", {31'b0, perr4}, 32'h0);
        rst4 = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rdy4) rdy_seen++;
        end
        chk("t4_no_ready", rdy_seen, 0);
        req(1'b0, 1'b0, 8'h30, 32'h0, rd, lat);
        chk("t4_prior_value", rd, 32'h0BADF00D);

        // Test 5: zero wait states, back-to-back requests.
        req(1'b1, 1'b1, 8'h05, 32'h00000077, rd, lat);
        chk("t5_write_lat", lat, 1);
        req(1'b1, 1'b0, 8'h05, 32'h0, rd, lat);
        chk("t5_read_lat",  lat, 1);
        chk("t5_read_data", rd,  32'h00000077);
        chk("t5_no_perr", {31'b0, perr0}, 32'h0);
        req(1'b1, 1'b0, 8'h05, 32'h0, rd, lat);
        chk("t5_b2b_lat",  lat, 1);
        chk("t5_no_perr2", {31'b0, perr0}, 32'h0);

        // Test 6: two writes at the address extremes, then reads in order.
        req(1'b0, 1'b1, 8'hFF, 32'hA5A5A5A5, rd, lat);
        req(1'b0, 1'b1, 8'h00, 32'h5A5A5A5A, rd, lat);
        chk("t6_dout_hold_after_writes", dout4, 32'h0BADF00D);
        req(1'b0, 1'b0, 8'hFF, 32'h0, rd, lat);
        chk("t6_read_ff", rd, 32'hA5A5A5A5);
        req(1'b0, 1'b0, 8'h00, 32'h0, rd, lat);
        chk("t6_read_00", rd, 32'h5A5A5A5A);
        chk("t6_lat", lat, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
